// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the multi-chunk add sequencer.
// Chunk geometry is fixed at a 5-bit adder slice supporting effective widths 2..5.
package multiword_add_sequencer_pkg;

  localparam int unsigned CHUNK_W = 5;
  localparam int unsigned N_W     = 3;
  localparam int unsigned N_MIN   = 2;
  localparam int unsigned N_MAX   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One slice request presented to the external adder
  typedef struct packed {
    logic [N_W-1:0]     n;
    logic [CHUNK_W-1:0] a;
    logic [CHUNK_W-1:0] b;
    logic               ci;
  } add_req_t;

  function automatic logic n_legal(input logic [N_W-1:0] n);
    return (32'(n) >= N_MIN) && (32'(n) <= N_MAX);
  endfunction

  function automatic logic [CHUNK_W-1:0] n_mask(input logic [N_W-1:0] n);
    logic [CHUNK_W-1:0] m;
    case (n)
      3'd0:    m = 5'b00000;
      3'd1:    m = 5'b00001;
      3'd2:    m = 5'b00011;
      3'd3:    m = 5'b00111;
      3'd4:    m = 5'b01111;
      default: m = 5'b11111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// Width-configurable 5-bit slice adder (n = 2..5): 2-bit ripple low part, carry-selected upper part.
// Sum bits at and above n are forced to 0; co is the carry into bit n.
module carry_select_adder
  import multiword_add_sequencer_pkg::*;
(
  input  logic [N_W-1:0]     n,
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] sum,
  output logic               co
);

  logic [CHUNK_W-1:0] am;
  logic [CHUNK_W-1:0] bm;
  logic [2:0]         lo;
  logic [3:0]         hi0;
  logic [3:0]         hi1;
  logic [5:0]         full;

  always_comb begin
    am   = a & n_mask(n);
    bm   = b & n_mask(n);
    lo   = {1'b0, am[1:0]} + {1'b0, bm[1:0]} + {2'b00, ci};
    hi0  = {1'b0, am[4:2]} + {1'b0, bm[4:2]};
    hi1  = {1'b0, am[4:2]} + {1'b0, bm[4:2]} + 4'd1;
    full = {(lo[2] ? hi1 : hi0), lo[1:0]};
    sum  = full[4:0] & n_mask(n);
    // Masked inputs keep everything above bit n clear, so bit n is the slice carry
    case (n)
      3'd2:    co = full[2];
      3'd3:    co = full[3];
      3'd4:    co = full[4];
      3'd5:    co = full[5];
      default: co = 1'b0;
    endcase
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Sequences an external 5-bit slice adder over NUM_CHUNKS chunks of n bits, rippling carry per clock.
// Define ADDSEQ_SUB_EN to add the in_sub port (A - B via ~B with forced carry-in).
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_CHUNKS = 4,
  localparam int unsigned OP_W       = NUM_CHUNKS * CHUNK_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_W-1:0]      in_n,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic                in_ci,
`ifdef ADDSEQ_SUB_EN
  input  logic                in_sub,
`endif
  output logic                err,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OP_W-1:0]     res_sum,
  output logic                res_co,
  output logic [N_W-1:0]      add_n,
  output logic [CHUNK_W-1:0]  add_a,
  output logic [CHUNK_W-1:0]  add_b,
  output logic                add_ci,
  input  logic [CHUNK_W-1:0]  add_sum,
  input  logic                add_co
);

  localparam int unsigned POS_W = $clog2(OP_W + CHUNK_W + 1);
  localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [N_W-1:0]     n_q;
  logic [N_W-1:0]     n_d;
  logic [OP_W-1:0]    a_q;
  logic [OP_W-1:0]    a_d;
  logic [OP_W-1:0]    b_q;
  logic [OP_W-1:0]    b_d;
  logic [POS_W-1:0]   pos_q;
  logic [POS_W-1:0]   pos_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [OP_W-1:0]    sum_d;
  logic               co_d;
  logic               valid_d;
  logic               err_d;
  logic               ready_d;
  add_req_t           add_q;
  add_req_t           add_d;
  logic               sub_req;
  logic               accept;

`ifdef ADDSEQ_SUB_EN
  assign sub_req = in_sub;
`else
  assign sub_req = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  assign add_n  = add_q.n;
  assign add_a  = add_q.a;
  assign add_b  = add_q.b;
  assign add_ci = add_q.ci;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && n_legal(in_n)) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of datapath and registered outputs; add_* is staged one cycle ahead of its use
  always_comb begin
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    sum_d   = res_sum;
    co_d    = res_co;
    valid_d = res_valid;
    err_d   = 1'b0;
    add_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (n_legal(in_n)) begin
            n_d      = in_n;
            a_d      = in_a;
            b_d      = sub_req ? ~in_b : in_b;
            pos_d    = '0;
            cnt_d    = '0;
            sum_d    = '0;
            co_d     = 1'b0;
            add_d.n  = in_n;
            add_d.a  = in_a[CHUNK_W-1:0] & n_mask(in_n);
            add_d.b  = b_d[CHUNK_W-1:0] & n_mask(in_n);
            add_d.ci = sub_req | in_ci;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        sum_d = res_sum | (OP_W'(add_sum & n_mask(n_q)) << pos_q);
        pos_d = pos_q + POS_W'(n_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          co_d    = add_co;
          valid_d = 1'b1;
        end else begin
          add_d.n  = n_q;
          add_d.a  = CHUNK_W'(a_q >> pos_d) & n_mask(n_q);
          add_d.b  = CHUNK_W'(b_q >> pos_d) & n_mask(n_q);
          add_d.ci = add_co;
        end
      end
      ST_DONE: if (res_ready) valid_d = 1'b0;
      default: ;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pos_q     <= '0;
      cnt_q     <= '0;
      res_sum   <= '0;
      res_co    <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      add_q     <= '0;
    end else begin
      n_q       <= n_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      res_sum   <= sum_d;
      res_co    <= co_d;
      res_valid <= valid_d;
      err       <= err_d;
      in_ready  <= ready_d;
      add_q     <= add_d;
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with carry_select_adder as the slice adder.
// Expected results come from an integer model pushed to a scoreboard at request time.
module tb_multiword_add_sequencer;

  localparam int unsigned NC   = 4;
  localparam int unsigned OPW  = NC * 5;

  typedef struct packed {
    logic           co;
    logic [OPW-1:0] sum;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_n;
  logic [OPW-1:0] in_a;
  logic [OPW-1:0] in_b;
  logic           in_ci;
  logic           in_sub;
  logic           err;
  logic           res_valid;
  logic           res_ready;
  logic [OPW-1:0] res_sum;
  logic           res_co;
  logic [2:0]     add_n;
  logic [4:0]     add_a;
  logic [4:0]     add_b;
  logic           add_ci;
  logic [4:0]     add_sum;
  logic           add_co;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multiword_add_sequencer #(.NUM_CHUNKS(NC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
`ifdef ADDSEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .err(err), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_co(res_co),
    .add_n(add_n), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co)
  );

  carry_select_adder u_add (
    .n(add_n), .a(add_a), .b(add_b), .ci(add_ci), .sum(add_sum), .co(add_co)
  );

  function automatic exp_t model(input int unsigned n, input logic [OPW-1:0] a,
                                 input logic [OPW-1:0] b, input logic ci, input logic sub);
    logic [63:0] m, bb, t;
    int unsigned w;
    exp_t e;
    w  = n * NC;
    m  = (64'd1 << w) - 64'd1;
    bb = sub ? ~{44'd0, b} : {44'd0, b};
    t  = ({44'd0, a} & m) + (bb & m) + (sub ? 64'd1 : {63'd0, ci});
    e.sum = OPW'(t & m);
    e.co  = t[w];
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] n, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                      input logic ci, input logic sub);
    @(negedge clk);
    in_n = n; in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
    check("in_ready_before_req", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (n >= 3'd2 && n <= 3'd5) sb.push_back(model(n, a, b, ci, sub));
  endtask

  // Called right after send(): measures latency, compares, holds, then accepts
  task automatic get_result(input string tag, input int hold);
    int   k;
    exp_t e;
    logic [OPW-1:0] s0;
    logic c0;
    k = 0;
    while (res_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, NC);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    else check({tag, "_sb_empty"}, 0, 1);
    check({tag, "_sum"}, res_sum, e.sum);
    check({tag, "_co"}, res_co, e.co);
    s0 = res_sum; c0 = res_co;
    if (hold > 0) begin
      in_n = 3'd3; in_a = 20'h12345; in_b = 20'h54321; in_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_sum"}, res_sum, s0);
      check({tag, "_hold_co"}, res_co, c0);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_after_accept"}, res_valid, 0);
    check({tag, "_idle_after_accept"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_n = '0; in_a = '0; in_b = '0; in_ci = 1'b0;
    in_sub = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_add", {add_n, add_a, add_b, add_ci}, 0);

    // Full-width carry ripple through all chunks
    send(3'd5, 20'hFFFFF, 20'h00001, 1'b0, 1'b0);
    check("v1_in_ready_run", in_ready, 0);
    check("v1_add_slice0", {add_n, add_a, add_b, add_ci}, {3'd5, 5'h1F, 5'h01, 1'b0});
    get_result("v1", 0);

    // n=2 with garbage above the effective width
    send(3'd2, 20'hFFFB4, 20'h1235A, 1'b0, 1'b0);
    check("v2_add_slice0", {add_n, add_a, add_b, add_ci}, {3'd2, 5'h00, 5'h02, 1'b0});
    get_result("v2", 1);

    // Illegal widths: one-cycle err, no RUN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_n = (i == 0) ? 3'd6 : 3'd1; in_a = 20'h3; in_b = 20'h5; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("bad_n_err_pulse", err, 1);
      check("bad_n_in_ready", in_ready, 1);
      check("bad_n_add_idle", {add_n, add_a, add_b, add_ci}, 0);
      @(negedge clk);
      check("bad_n_err_clear", err, 0);
      check("bad_n_still_idle", in_ready, 1);
      check("bad_n_no_result", res_valid, 0);
    end

    // Result held while the consumer stalls
    send(3'd3, 20'h007FF, 20'h00001, 1'b0, 1'b0);
    get_result("v4", 3);

    // Reset during chunk 2 drops the operation
    send(3'd4, 20'hABCDE, 20'h12345, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_res_valid", res_valid, 0);
    check("midrst_add", {add_n, add_a, add_b, add_ci}, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_res_sum", res_sum, 0);
    repeat (6) @(negedge clk);
    check("midrst_no_late_result", res_valid, 0);
    send(3'd4, 20'h0BEEF, 20'h0CAFE, 1'b1, 1'b0);
    get_result("after_rst", 0);

    for (int i = 0; i < 6; i++) begin
      send(3'($urandom_range(2, 5)), 20'($urandom), 20'($urandom), 1'($urandom), 1'b0);
      get_result("rand", int'($urandom_range(0, 2)));
    end

`ifdef ADDSEQ_SUB_EN
    send(3'd5, 20'd10, 20'd3, 1'b0, 1'b1);
    get_result("sub_pos", 0);
    send(3'd5, 20'd3, 20'd10, 1'b1, 1'b1);
    get_result("sub_neg", 1);
    send(3'd3, 20'h00123, 20'h00456, 1'b0, 1'b1);
    get_result("sub_n3", 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
